// File: rtl/hazard_interlock_controller_pkg.sv
// Shared definitions for the hazard interlock controller: opcodes, instruction
// field positions, shadow-pipeline entry type and forwarding-select encoding.
package hazard_interlock_controller_pkg;

    localparam logic [3:0] OP_NOP   = 4'b0000;
    localparam logic [3:0] OP_STORE = 4'b1100;
    localparam logic [3:0] OP_LOAD  = 4'b1011;

    localparam int OP_MSB = 19;
    localparam int OP_LSB = 16;
    localparam int F1_MSB = 15;
    localparam int F1_LSB = 12;
    localparam int F2_MSB = 11;
    localparam int F2_LSB = 8;
    localparam int F3_MSB = 7;
    localparam int F3_LSB = 4;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    typedef struct packed {
        logic       valid;
        logic [3:0] rd;
        logic       is_load;
    } sb_entry_t;

    localparam sb_entry_t SB_EMPTY = '0;

    // The youngest in-flight producer wins when both EX and MEM hold the register.
    function automatic logic [1:0] fwd_select(input logic [3:0] rs,
                                              input logic       ex_valid,
                                              input logic [3:0] ex_rd,
                                              input logic       mem_valid,
                                              input logic [3:0] mem_rd);
        if (ex_valid && ex_rd == rs)
            return FWD_EXMEM;
        else if (mem_valid && mem_rd == rs)
            return FWD_MEMWB;
        return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_interlock_controller_operand_extract.sv
// hazard_operand_extract: maps a decode instruction to its source registers,
// destination and load flag; STORE takes its sources from f1/f2 instead of f2/f3.
module hazard_operand_extract
    import hazard_interlock_controller_pkg::*;
(
    input  logic [19:0] i_instr,
    output logic [3:0]  o_rs1,
    output logic [3:0]  o_rs2,
    output logic        o_uses_src,
    output logic        o_writes,
    output logic [3:0]  o_rd,
    output logic        o_is_load
);

    logic [3:0] w_op;
    logic [3:0] w_f1;
    logic [3:0] w_f2;
    logic [3:0] w_f3;
    logic       w_store;
    logic       w_unused;

    assign w_op    = i_instr[OP_MSB:OP_LSB];
    assign w_f1    = i_instr[F1_MSB:F1_LSB];
    assign w_f2    = i_instr[F2_MSB:F2_LSB];
    assign w_f3    = i_instr[F3_MSB:F3_LSB];
    assign w_store = (w_op == OP_STORE);

    assign o_rs1      = w_store ? w_f1 : w_f2;
    assign o_rs2      = w_store ? w_f2 : w_f3;
    assign o_uses_src = (w_op != OP_NOP);
    assign o_writes   = (w_op != OP_NOP) && !w_store;
    assign o_rd       = w_f1;
    assign o_is_load  = (w_op == OP_LOAD);

    assign w_unused = ^i_instr[F3_LSB-1:0];

endmodule

// File: rtl/hazard_interlock_controller.sv
// Decode-stage interlock: shadows EX/MEM/WB destinations and decides issue vs stall.
// Optional operand forwarding with load-use interlock when HAZARD_FORWARDING_EN is defined.
module hazard_interlock_controller
    import hazard_interlock_controller_pkg::*;
#(
    parameter int WB_BYPASS   = 1,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   id_valid,
    input  logic [19:0]            id_instruction,
    input  logic                   flush,
    output logic                   stall,
    output logic                   bubble,
    output logic                   issue,
    output logic [1:0]             fwdA_sel,
    output logic [1:0]             fwdB_sel,
    output logic [STALL_CNT_W-1:0] stall_count
);

    logic [3:0] w_rs1;
    logic [3:0] w_rs2;
    logic       w_uses_src;
    logic       w_writes;
    logic [3:0] w_rd;
    logic       w_is_load;
    logic       w_hazard;
    logic       w_unused;

    sb_entry_t              r_ex;
    sb_entry_t              r_mem;
    sb_entry_t              r_wb;
    logic [STALL_CNT_W-1:0] r_stall_count;

    hazard_operand_extract u_extract (
        .i_instr    (id_instruction),
        .o_rs1      (w_rs1),
        .o_rs2      (w_rs2),
        .o_uses_src (w_uses_src),
        .o_writes   (w_writes),
        .o_rd       (w_rd),
        .o_is_load  (w_is_load)
    );

`ifdef HAZARD_FORWARDING_EN
    // Only a load still in EX cannot be forwarded in time.
    assign w_hazard = w_uses_src && r_ex.valid && r_ex.is_load &&
                      (r_ex.rd == w_rs1 || r_ex.rd == w_rs2);
`else
    logic w_ex_hit;
    logic w_mem_hit;
    logic w_wb_hit;

    assign w_ex_hit  = r_ex.valid  && (r_ex.rd  == w_rs1 || r_ex.rd  == w_rs2);
    assign w_mem_hit = r_mem.valid && (r_mem.rd == w_rs1 || r_mem.rd == w_rs2);
    assign w_wb_hit  = r_wb.valid  && (r_wb.rd  == w_rs1 || r_wb.rd  == w_rs2);
    assign w_hazard  = w_uses_src &&
                       (w_ex_hit || w_mem_hit || (WB_BYPASS == 0 && w_wb_hit));
`endif

    assign stall  = id_valid && w_hazard && !flush;
    assign issue  = id_valid && !w_hazard && !flush;
    assign bubble = !issue;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ex          <= SB_EMPTY;
            r_mem         <= SB_EMPTY;
            r_wb          <= SB_EMPTY;
            r_stall_count <= '0;
        end else begin
            r_wb  <= r_mem;
            r_mem <= r_ex;
            r_ex  <= (issue && w_writes) ? {1'b1, w_rd, w_is_load} : SB_EMPTY;
            if (stall && r_stall_count != '1)
                r_stall_count <= r_stall_count + 1'b1;
        end
    end

    assign stall_count = r_stall_count;

`ifdef HAZARD_FORWARDING_EN
    logic [1:0] r_fwdA;
    logic [1:0] r_fwdB;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_fwdA <= FWD_RF;
            r_fwdB <= FWD_RF;
        end else if (issue && w_uses_src) begin
            r_fwdA <= fwd_select(w_rs1, r_ex.valid, r_ex.rd, r_mem.valid, r_mem.rd);
            r_fwdB <= fwd_select(w_rs2, r_ex.valid, r_ex.rd, r_mem.valid, r_mem.rd);
        end else begin
            r_fwdA <= FWD_RF;
            r_fwdB <= FWD_RF;
        end
    end

    assign fwdA_sel = r_fwdA;
    assign fwdB_sel = r_fwdB;
`else
    assign fwdA_sel = FWD_RF;
    assign fwdB_sel = FWD_RF;
`endif

    assign w_unused = ^{r_ex.is_load, r_mem.is_load, r_wb, (WB_BYPASS != 0)};

endmodule

// File: doc/hazard_interlock_controller.md
Name: hazard_interlock_controller

Overview:
- Pipeline interlock and scheduling controller for the 5-stage, 20-bit-instruction processor.
- Sits beside the decode stage and shadows the in-flight destination registers of the EX, MEM and WB stages.
- Decides each cycle whether the decode-stage instruction issues to EX, or whether decode stalls and a bubble is injected.
- Optionally generates operand-forwarding selects for the EX stage.

Parameters:
- WB_BYPASS, 1, 1 = register file write in WB is visible to a decode read in the same cycle, so the WB stage is not a hazard source.
- STALL_CNT_W, 16, width of the saturating stall counter.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- id_valid  in  1  decode holds a valid instruction.
- id_instruction  in  20  decode instruction: op[19:16], f1[15:12], f2[11:8], f3[7:4].
- flush  in  1  taken branch resolved in EX; squash the decode instruction.
- stall  out  1  hold the PC and the IF/ID register this cycle.
- bubble  out  1  EX stage loads a NOP next edge.
- issue  out  1  decode instruction advances to EX next edge.
- fwdA_sel  out  2  EX operand-A source: 00 = RF, 01 = EX/MEM, 10 = MEM/WB.
- fwdB_sel  out  2  EX operand-B source, same encoding as fwdA_sel.
- stall_count  out  STALL_CNT_W  cycles stalled since reset, saturating.

Behaviour:
- Opcode decode:
  - NOP = 0000: reads nothing, writes nothing.
  - STORE = 1100: reads rs1 = f1, rs2 = f2; writes nothing.
  - LOAD = 1011: reads rs1 = f2, rs2 = f3; writes rd = f1; marked is_load.
  - All other opcodes: read rs1 = f2, rs2 = f3; write rd = f1.
  - Register 0 is not special.
- Shadow pipeline: three registered entries, ex, mem and wb, each holding {valid, rd, is_load}.
  - Every edge: wb <= mem; mem <= ex.
  - ex <= the issued instruction's {writes, rd, is_load} when issue = 1, else 0.
- Hazard, without forwarding: a source register of a valid, non-NOP decode instruction equals rd of a valid ex or mem entry. The wb entry is also checked when WB_BYPASS = 0.
- Output equations (combinational, same cycle):
  - stall = id_valid & hazard & ~flush.
  - issue = id_valid & ~hazard & ~flush.
  - bubble = ~issue.
- Latency: a dependent instruction directly behind a writer stalls 2 cycles (3 cycles if WB_BYPASS = 0), then issues.
- Flush:
  - Has priority over the hazard: stall = 0, issue = 0, bubble = 1.
  - The ex entry loads 0.
  - The mem and wb entries shift normally.
- id_valid = 0: stall = 0, issue = 0, bubble = 1; no count.
- stall_count:
  - Increments on each edge where stall = 1.
  - Saturates at all ones; no wrap-around.
- Reset (asynchronous, any time, including mid-stall):
  - All shadow entries cleared, stall_count = 0, fwd selects = 00.
  - Combinational outputs then follow the inputs: with id_valid = 0, stall = 0, issue = 0, bubble = 1.
  - No stall persists after reset.

Optional Feature:
- Macro: HAZARD_FORWARDING_EN.
- Defined:
  - hazard = a source matches a valid ex entry with is_load = 1 (load-use interlock, exactly 1 stall cycle).
  - fwdA_sel / fwdB_sel are registered on issue, for each source:
    - 01 if it matches the ex entry (youngest wins);
    - else 10 if it matches the mem entry;
    - else 00.
  - Not issuing loads 00.
- Undefined: full interlock as described under Behaviour; fwdA_sel and fwdB_sel are constant 00.

Decomposition:
- Shared package holds:
  - opcode constants OP_NOP, OP_STORE, OP_LOAD;
  - field bit positions;
  - the scoreboard entry typedef {valid, rd[3:0], is_load};
  - the forwarding-select encoding constants.
- Natural sub-module: hazard_operand_extract, a combinational unit mapping an instruction to {rs1, rs2, uses_src, writes, rd, is_load}. It encapsulates the STORE field swap.

Test Plan:
1. Reset: drive reset = 0 mid-run with entries valid -> all fwd selects 00 and stall_count = 0 immediately; with id_valid = 0, stall = 0 and bubble = 1. Release, no stall.
2. RAW, no forwarding, WB_BYPASS = 1: issue 0001_0011_0001_0010_0000 (writes r3), then 0001_0100_0011_0000_0000 (reads r3) -> stall = 1 for exactly 2 cycles, then issue = 1; stall_count = 2.
3. STORE swap: writer of r5, then STORE 1100_0101_0110_0000_0000 -> stall. Writer of r7, then the same STORE -> no stall.
4. Flush while stalled (same setup as scenario 2): assert flush on the first stall cycle -> stall = 0, bubble = 1, issue = 0; stall_count unchanged.
5. Forwarding (HAZARD_FORWARDING_EN):
   - LOAD r2 then a reader of r2 in f2 -> 1 stall cycle, then issue with fwdA_sel = 10.
   - Writer of r4 then a reader of r4 in f3 -> no stall, fwdB_sel = 01.
6. Saturation, STALL_CNT_W = 4: hold a hazard for 20 cycles -> stall_count stops at 15.
